// File: rtl/pd_axis_sched_if.sv
// pd_axis_sched_if: start/done handshake between the axis scheduler and the shared PD math unit
interface pd_axis_sched_if;
   logic       pd_start;
   logic [1:0] pd_axis;
   logic [9:0] pd_err;
   logic       pd_done;
   logic [9:0] pd_term;
   modport master (output pd_start, pd_axis, pd_err, input pd_done, pd_term);
   modport slave (input pd_start, pd_axis, pd_err, output pd_done, pd_term);
endinterface

// File: rtl/pd_axis_sched.sv
// pd_axis_sched: time-multiplexes one PD unit over pitch/roll/yaw; PD_SCHED_PEND_EN adds a one-deep pending sample buffer
module pd_axis_sched #(
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            vld,
   input  logic [15:0]     d_ptch,
   input  logic [15:0]     d_roll,
   input  logic [15:0]     d_yaw,
   input  logic [15:0]     ptch,
   input  logic [15:0]     roll,
   input  logic [15:0]     yaw,
   pd_axis_sched_if.master pd,
   output logic [9:0]      ptch_term,
   output logic [9:0]      roll_term,
   output logic [9:0]      yaw_term,
   output logic            terms_vld,
   output logic            busy,
   output logic            ovr,
   output logic            to_err
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [1:0]       state_q, state_d, axis_q, axis_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [2:0][15:0] act_q, act_d, des_q, des_d, in_act, in_des;
   logic [2:0][9:0]  term_q, term_d;
   logic [9:0]       err_q, err_d;
   logic             to_err_q, to_err_d, ovr_q, ovr_d;
`ifdef PD_SCHED_PEND_EN
   logic             pend_q, pend_d;
   logic [2:0][15:0] pact_q, pact_d, pdes_q, pdes_d;
`endif
   function automatic logic [9:0] sat(input logic [15:0] a, input logic [15:0] d);
      logic signed [16:0] x;
      x = $signed({a[15], a}) - $signed({d[15], d});
      return (x > 17'sd511) ? 10'h1ff : (x < -17'sd512) ? 10'h200 : x[9:0];
   endfunction
   assign in_act = {yaw, roll, ptch};
   assign in_des = {d_yaw, d_roll, d_ptch};
   assign pd.pd_start = state_q == ISSUE;
   assign pd.pd_axis = axis_q;
   assign pd.pd_err = err_q;
   assign {yaw_term, roll_term, ptch_term} = term_q;
   assign terms_vld = state_q == DONE;
   assign busy = state_q != IDLE;
   assign ovr = ovr_q;
   assign to_err = to_err_q;
   // next-state: sample capture, per-axis issue/wait with timeout, term storage and the error latched for ISSUE
   always_comb begin
      state_d = state_q;
      axis_d = axis_q;
      cnt_d = cnt_q;
      act_d = act_q;
      des_d = des_q;
      term_d = term_q;
      to_err_d = to_err_q;
      case (state_q)
         IDLE: if (vld) begin
            act_d = in_act;
            des_d = in_des;
            axis_d = 2'd0;
            to_err_d = 1'b0;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d = 8'd0;
            state_d = WAIT;
         end
         WAIT: if (pd.pd_done || cnt_q == TO_LAST) begin
            term_d[axis_q] = pd.pd_done ? pd.pd_term : 10'd0;
            to_err_d = to_err_q | ~pd.pd_done;
            axis_d = (axis_q == 2'd2) ? axis_q : axis_q + 2'd1;
            state_d = (axis_q == 2'd2) ? DONE : ISSUE;
         end else cnt_d = cnt_q + 8'd1;
         default: state_d = IDLE;
      endcase
`ifdef PD_SCHED_PEND_EN
      pend_d = pend_q;
      pact_d = (vld && state_q != IDLE) ? in_act : pact_q;
      pdes_d = (vld && state_q != IDLE) ? in_des : pdes_q;
      ovr_d = vld && pend_q && state_q != IDLE && state_q != DONE;
      if (state_q == DONE) begin
         if (pend_q || vld) begin
            act_d = pend_q ? pact_q : in_act;
            des_d = pend_q ? pdes_q : in_des;
            axis_d = 2'd0;
            to_err_d = 1'b0;
            state_d = ISSUE;
         end
         pend_d = pend_q && vld;
      end else if (vld && state_q != IDLE) pend_d = 1'b1;
`else
      ovr_d = vld && state_q != IDLE;
`endif
      err_d = (state_d == ISSUE) ? sat(act_d[axis_d], des_d[axis_d]) : err_q;
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         axis_q <= 2'd0;
         cnt_q <= 8'd0;
         act_q <= '0;
         des_q <= '0;
         term_q <= '0;
         err_q <= 10'd0;
         to_err_q <= 1'b0;
         ovr_q <= 1'b0;
`ifdef PD_SCHED_PEND_EN
         pend_q <= 1'b0;
         pact_q <= '0;
         pdes_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         axis_q <= axis_d;
         cnt_q <= cnt_d;
         act_q <= act_d;
         des_q <= des_d;
         term_q <= term_d;
         err_q <= err_d;
         to_err_q <= to_err_d;
         ovr_q <= ovr_d;
`ifdef PD_SCHED_PEND_EN
         pend_q <= pend_d;
         pact_q <= pact_d;
         pdes_q <= pdes_d;
`endif
      end
   end
endmodule

// File: tb/tb_pd_axis_sched.sv
// tb_pd_axis_sched: directed scoreboard bench for pd_axis_sched with an echoing PD unit model
module tb_pd_axis_sched;
   localparam int TO = 16;
`ifdef PD_SCHED_PEND_EN
   localparam bit PEND = 1'b1;
`else
   localparam bit PEND = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
   logic [15:0] d_ptch = 0, d_roll = 0, d_yaw = 0, ptch = 0, roll = 0, yaw = 0;
   logic [9:0] ptch_term, roll_term, yaw_term;
   logic terms_vld, busy, ovr, to_err;
   pd_axis_sched_if ifc();
   pd_axis_sched #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .vld(vld),
      .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
      .ptch(ptch), .roll(roll), .yaw(yaw),
      .pd(ifc),
      .ptch_term(ptch_term), .roll_term(roll_term), .yaw_term(yaw_term),
      .terms_vld(terms_vld), .busy(busy), .ovr(ovr), .to_err(to_err)
   );
   always #5 clk = ~clk;
   int checks = 0, failures = 0, ovr_cnt = 0;
   logic [11:0] err_sb[$];
   logic [29:0] trm_sb[$];
   logic [2:0] mute = 3'b000;
   logic force_done = 1'b0;
   logic [29:0] last_t = 30'd0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [9:0] m_err(input logic [15:0] a, input logic [15:0] d);
      int x;
      x = int'($signed(a)) - int'($signed(d));
      if (x > 511) x = 511;
      if (x < -512) x = -512;
      return 10'(x);
   endfunction
   task automatic send(input logic [15:0] p, input logic [15:0] dp, input logic [15:0] r,
                       input logic [15:0] dr, input logic [15:0] y, input logic [15:0] dy, input bit acc);
      logic [9:0] e0, e1, e2;
      logic [29:0] t;
      @(negedge clk);
      if (acc) begin
         e0 = m_err(p, dp);
         e1 = m_err(r, dr);
         e2 = m_err(y, dy);
         err_sb.push_back({2'd0, e0});
         err_sb.push_back({2'd1, e1});
         err_sb.push_back({2'd2, e2});
         t = {mute[0] ? 10'd0 : e0, mute[1] ? 10'd0 : e1, mute[2] ? 10'd0 : e2};
         trm_sb.push_back(t);
         last_t = t;
      end
      ptch = p; d_ptch = dp; roll = r; d_roll = dr; yaw = y; d_yaw = dy;
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
   endtask
   task automatic lat(output int n);
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (terms_vld) break;
      end
   endtask
   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while ((busy || err_sb.size() != 0 || trm_sb.size() != 0) && n < 300);
      chk("idle_reached", 32'(busy || err_sb.size() != 0 || trm_sb.size() != 0), 0);
   endtask
   task automatic chk_terms(input string tag, input logic [29:0] t);
      chk({tag, "_ptch_term"}, ptch_term, t[29:20]);
      chk({tag, "_roll_term"}, roll_term, t[19:10]);
      chk({tag, "_yaw_term"}, yaw_term, t[9:0]);
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_pd_start"}, ifc.pd_start, 0);
      chk({tag, "_pd_axis"}, ifc.pd_axis, 0);
      chk({tag, "_pd_err"}, ifc.pd_err, 0);
      chk_terms(tag, 30'd0);
      chk({tag, "_terms_vld"}, terms_vld, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ovr"}, ovr, 0);
      chk({tag, "_to_err"}, to_err, 0);
   endtask
   // PD unit model answers one cycle after pd_start; also the output monitor popping the scoreboard
   initial begin
      logic ps;
      logic [1:0] pa;
      logic [9:0] pe;
      logic [11:0] e;
      logic [29:0] t;
      ps = 1'b0; pa = 2'd0; pe = 10'd0;
      ifc.pd_done = 1'b0;
      ifc.pd_term = 10'd0;
      forever begin
         @(posedge clk);
         #1;
         if (ovr) ovr_cnt++;
         if (ifc.pd_start) begin
            chk("sb_err_avail", 32'(err_sb.size() > 0), 1);
            if (err_sb.size() > 0) begin
               e = err_sb.pop_front();
               chk("pd_axis", ifc.pd_axis, e[11:10]);
               chk("pd_err", ifc.pd_err, e[9:0]);
            end
         end
         if (terms_vld) begin
            chk("sb_terms_avail", 32'(trm_sb.size() > 0), 1);
            if (trm_sb.size() > 0) begin
               t = trm_sb.pop_front();
               chk_terms("sb", t);
            end
         end
         ifc.pd_done = (ps && !mute[pa]) || force_done;
         ifc.pd_term = (ps && !mute[pa]) ? pe : 10'h155;
         ps = ifc.pd_start;
         pa = ifc.pd_axis;
         pe = ifc.pd_err;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      bit found;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;
      send(16'd100, 16'd40, 16'hFFEC, 16'd0, 16'd5, 16'd5, 1'b1);
      lat(n);
      chk("lat_basic", n, 6);
      wait_idle();
      chk_terms("basic", {10'd60, 10'h3EC, 10'd0});
      send(16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'hFFFD, 16'd1000, 1'b1);
      wait_idle();
      chk_terms("sat", {10'h1FF, 10'h200, 10'h200});
      mute = 3'b010;
      send(16'd300, 16'd100, 16'd50, 16'd10, 16'd0, 16'd7, 1'b1);
      lat(n);
      chk("lat_timeout", n, 6 + TO - 1);
      chk("to_err_set", to_err, 1);
      wait_idle();
      chk_terms("timeout", {10'd200, 10'd0, 10'h3F9});
      chk("to_err_sticky", to_err, 1);
      mute = 3'b000;
      send(16'd10, 16'd20, 16'd30, 16'd0, 16'hFF00, 16'hFF10, 1'b1);
      chk("to_err_clear", to_err, 0);
      wait_idle();
      ovr_cnt = 0;
      send(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 1'b1);
      send(16'd400, 16'd0, 16'd0, 16'd300, 16'd7, 16'd1, PEND);
      wait_idle();
      chk("ovr_count", ovr_cnt, PEND ? 0 : 1);
      chk_terms("overrun", last_t);
      send(16'd70, 16'd0, 16'd80, 16'd0, 16'd90, 16'd0, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(posedge clk);
         #1;
         found = busy && !ifc.pd_start && ifc.pd_axis == 2'd1 && !terms_vld;
      end
      chk("found_wait_axis1", found, 1);
      @(negedge clk);
      rst_n = 1'b0;
      err_sb.delete();
      trm_sb.delete();
      @(negedge clk);
      chk_reset("midrst");
      rst_n = 1'b1;
      send(16'hFFF6, 16'd5, 16'd8, 16'd1, 16'd0, 16'd3, 1'b1);
      lat(n);
      chk("lat_after_rst", n, 6);
      wait_idle();
      force_done = 1'b1;
      repeat (4) @(negedge clk);
      chk_terms("spur_idle", last_t);
      send(16'd33, 16'd11, 16'd0, 16'd44, 16'd2, 16'd1, 1'b1);
      wait_idle();
      force_done = 1'b0;
      chk_terms("spur_run", last_t);
      chk("sb_drained", 32'(err_sb.size() + trm_sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pd_axis_sched.md
Name: pd_axis_sched

Overview:
- Time-multiplexes one shared PD math unit across the pitch, roll and yaw axes of the flight controller.
- On each valid inertial reading it captures the desired and actual angles and forms a saturated 10-bit error per axis.
- It issues three sequential start/done transactions to the PD unit and stores the three returned terms.
- Its registered outputs feed the motor-speed mixing stage that produces frnt/bck/lft/rght speeds.

Parameters:
- TIMEOUT, 16, max cycles spent in WAIT for pd_done before the axis is abandoned; legal range 2..255.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- vld  in  1  new inertial reading valid, one-cycle pulse.
- d_ptch, d_roll, d_yaw  in  16 each  desired angles, signed.
- ptch, roll, yaw  in  16 each  actual angles, signed.
- pd_start  out  1  one-cycle start pulse to the shared PD unit.
- pd_axis  out  2  axis being computed: 0=ptch, 1=roll, 2=yaw; 3 never driven.
- pd_err  out  10  signed saturated error for pd_axis; held stable from pd_start until pd_done.
- pd_done  in  1  PD unit result valid.
- pd_term  in  10  signed PD result; sampled only when pd_done=1 in WAIT.
- ptch_term, roll_term, yaw_term  out  10 each  signed stored PD terms.
- terms_vld  out  1  one-cycle pulse when all three terms of a sample are updated.
- busy  out  1  high whenever state != IDLE.
- ovr  out  1  one-cycle pulse when a vld is dropped.
- to_err  out  1  sticky timeout flag.

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE.
  - All outputs 0; all terms 0.
  - Captured inputs, axis counter and timeout counter cleared.
  - Reset mid-transaction abandons the sample; the PD unit is not notified.
- Error arithmetic: err = sign-extended actual − desired, 17-bit signed, saturated to [−512, 511], then truncated to 10 bits.
- Errors are computed from the registers captured at vld, so later input changes have no effect on the sample in flight.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: on vld, capture all six angles, set axis=0, clear to_err, go to ISSUE.
  - ISSUE: pd_start=1 for exactly this cycle, pd_axis=axis, go to WAIT, clear the timeout counter.
  - WAIT with pd_done=1: store pd_term into the selected term register.
    - If axis=2, go to DONE.
    - Otherwise axis+1, go to ISSUE.
  - WAIT with pd_done=0: increment the timeout counter.
    - When the counter reaches TIMEOUT−1 without pd_done, store 0 into the selected term, set to_err, and advance as if done.
  - DONE: terms_vld=1 for this cycle, go to IDLE.
- pd_done asserted in ISSUE, IDLE or DONE is ignored.
- pd_err and pd_axis are registered and stable from ISSUE through the end of WAIT.
- Latency with pd_done returned in the first WAIT cycle:
  - vld sampled at edge k produces pd_start in cycles k+1, k+3 and k+5.
  - terms_vld is high in the cycle after edge k+6.
- Term registers update only on store and hold otherwise; they remain stable while terms_vld=1.
- vld while busy=1 (including DONE): the sample is dropped and ovr pulses in the next cycle; the in-flight sample is unaffected.
- vld in the same cycle the FSM moves DONE→IDLE is dropped, since the state is still DONE.

Optional Feature:
- Macro: PD_SCHED_PEND_EN.
- Defined:
  - A one-deep pending buffer holds the six angles of a vld that arrives while busy.
  - From DONE, the FSM goes directly to ISSUE with the pending sample (axis=0) and clears pending.
  - ovr pulses only when vld arrives while pending is already full; the newer sample overwrites the pending one.
  - Pending is cleared on reset.
- Undefined: busy-time vld is dropped with ovr, exactly as in Behaviour.

Test Plan:
- Basic sequence: ptch=100, d_ptch=40, roll=−20, d_roll=0, yaw=5, d_yaw=5, vld pulse; PD model echoes term=err one cycle after start → pd_err sequence 60, −20, 0; terms_vld 6 cycles after vld; ptch_term=60, roll_term=−20, yaw_term=0.
- Saturation: ptch=16'h7FFF, d_ptch=16'h8000 → pd_err=511; roll=16'h8000, d_roll=16'h7FFF → pd_err=−512 (10'h200).
- Timeout: PD model never answers axis 1 with TIMEOUT=16 → roll_term=0; to_err=1 after 16 WAIT cycles; yaw still issued; terms_vld still pulses; next accepted vld clears to_err.
- Overrun: second vld 2 cycles after the first → ovr pulses once; terms reflect the first sample. With PD_SCHED_PEND_EN, no ovr; a second terms_vld follows with the second sample's terms.
- Reset mid-WAIT on axis 1: rst_n=0 for one edge → all outputs 0, busy=0; next vld runs a full clean sequence starting at axis 0.
- Spurious done: pd_done held high in IDLE and ISSUE → no term register changes; storing occurs only in WAIT.
